// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Frame-synchronous game controller for the sprite compositor. Collision flags
// from the pixel pipeline are latched during a frame and applied only on the
// end-of-frame tick, so no sprite moves or changes mid-frame.
//
// Ports:
//   clk_i            system/pixel clock
//   reset_i          synchronous, active-high reset
//   start_i          one-cycle start/restart pulse (honoured in IDLE/OVER only)
//   frame_tick_i     one-cycle pulse at the end of the visible frame
//   hit_fruit_i      snake head overlaps fruit this cycle
//   hit_barrier_i    snake head overlaps barrier this cycle
//   state_game_o     compositor state code (IDLE=000, PLAY=001, blink=010, OVER=100)
//   lives_o          remaining lives
//   heart_en_o       heart visibility, thermometer-coded from lives
//   score_o          fruits eaten, saturating
//   set_speed_o      one-cycle speed-up pulse every SPEED_STEP fruits
//   new_position_x_o fruit x position
//   new_position_y_o fruit y position
//   move_sprite_o    one-cycle pulse: fruit adopts the new position
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned HIT_FRAMES = 60,
  parameter int unsigned SPEED_STEP = 5,
  parameter int unsigned FRUIT_X0   = 400,
  parameter int unsigned FRUIT_Y0   = 400,
  parameter int unsigned X_MIN      = 50,
  parameter int unsigned Y_MIN      = 50,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               frame_tick_i,
  input  logic               hit_fruit_i,
  input  logic               hit_barrier_i,
  output logic [2:0]         state_game_o,
  output logic [1:0]         lives_o,
  output logic [2:0]         heart_en_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               set_speed_o,
  output logic [10:0]        new_position_x_o,
  output logic [9:0]         new_position_y_o,
  output logic               move_sprite_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [1:0]  LIVES_INIT_C = 2'(LIVES_INIT);
  localparam logic [7:0]  HIT_FRAMES_C = 8'(HIT_FRAMES);
  localparam logic [7:0]  SPEED_STEP_C = 8'(SPEED_STEP);
  localparam logic [10:0] FRUIT_X0_C   = 11'(FRUIT_X0);
  localparam logic [9:0]  FRUIT_Y0_C   = 10'(FRUIT_Y0);
  localparam logic [10:0] X_MIN_C      = 11'(X_MIN);
  localparam logic [9:0]  Y_MIN_C      = 10'(Y_MIN);
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  // Galois right-shift LFSR step: feed the shifted-out bit back through the mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    if (v[0]) begin
      r = {1'b0, v[15:1]} ^ LFSR_MASK;
    end else begin
      r = {1'b0, v[15:1]};
    end
    return r;
  endfunction

  // Heart enables: one heart per remaining life, filled from bit 0 upwards.
  function automatic logic [2:0] hearts(input logic [1:0] l);
    logic [2:0] h;
    case (l)
      2'd0:    h = 3'b000;
      2'd1:    h = 3'b001;
      2'd2:    h = 3'b011;
      2'd3:    h = 3'b111;
      default: h = 3'b000;
    endcase
    return h;
  endfunction

  // Registers and next-state values.
  state_e             state_q, state_d;
  logic [7:0]         hit_timer_q, hit_timer_d;
  logic [7:0]         speed_cnt_q, speed_cnt_d;
  logic               fruit_pend_q, fruit_pend_d;
  logic               barrier_pend_q, barrier_pend_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [10:0]        pos_x_q, pos_x_d;
  logic [9:0]         pos_y_q, pos_y_d;
  logic               move_q, move_d;
  logic               set_speed_q, set_speed_d;
  logic [2:0]         state_game_q, state_game_d;
  logic [2:0]         heart_q, heart_d;

  // Shared decode of the current cycle's events.
  logic       in_game_s;
  logic       idle_s;
  logic       start_go_s;
  logic       tick_go_s;
  logic       fruit_now_s;
  logic       barrier_now_s;
  logic       fruit_apply_s;
  logic       barrier_apply_s;
  logic [1:0] lives_dec_s;
  logic [7:0] speed_inc_s;

  assign in_game_s   = (state_q == ST_PLAY) || (state_q == ST_HIT);
  assign idle_s      = (state_q == ST_IDLE) || (state_q == ST_OVER);
  // Start wins over a coincident tick because ticks only act in PLAY/HIT.
  assign start_go_s  = start_i && idle_s;
  assign tick_go_s   = frame_tick_i && in_game_s;
  // A hit in the tick cycle itself is folded into that tick.
  assign fruit_now_s     = fruit_pend_q || (hit_fruit_i && in_game_s);
  assign barrier_now_s   = barrier_pend_q || (hit_barrier_i && (state_q == ST_PLAY));
  assign fruit_apply_s   = tick_go_s && fruit_now_s;
  assign barrier_apply_s = tick_go_s && barrier_now_s && (state_q == ST_PLAY);
  assign lives_dec_s     = lives_q - 2'd1;
  assign speed_inc_s     = speed_cnt_q + 8'd1;
  assign lfsr_d          = lfsr_next(lfsr_q);

  // State register and all registered datapath/outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      hit_timer_q    <= 8'd0;
      speed_cnt_q    <= 8'd0;
      fruit_pend_q   <= 1'b0;
      barrier_pend_q <= 1'b0;
      lfsr_q         <= LFSR_SEED;
      lives_q        <= 2'd0;
      score_q        <= '0;
      pos_x_q        <= FRUIT_X0_C;
      pos_y_q        <= FRUIT_Y0_C;
      move_q         <= 1'b0;
      set_speed_q    <= 1'b0;
      state_game_q   <= 3'b000;
      heart_q        <= 3'b000;
    end else begin
      state_q        <= state_d;
      hit_timer_q    <= hit_timer_d;
      speed_cnt_q    <= speed_cnt_d;
      fruit_pend_q   <= fruit_pend_d;
      barrier_pend_q <= barrier_pend_d;
      lfsr_q         <= lfsr_d;
      lives_q        <= lives_d;
      score_q        <= score_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      move_q         <= move_d;
      set_speed_q    <= set_speed_d;
      state_game_q   <= state_game_d;
      heart_q        <= heart_d;
    end
  end

  // Next-state logic: start, barrier-driven HIT/OVER entry, HIT timer expiry.
  always_comb begin
    state_d     = state_q;
    hit_timer_d = hit_timer_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_go_s) begin
          state_d     = ST_PLAY;
          hit_timer_d = 8'd0;
        end else begin
          state_d     = state_q;
          hit_timer_d = hit_timer_q;
        end
      end
      ST_PLAY: begin
        if (barrier_apply_s) begin
          if (lives_dec_s == 2'd0) begin
            state_d     = ST_OVER;
            hit_timer_d = 8'd0;
          end else begin
            state_d     = ST_HIT;
            hit_timer_d = HIT_FRAMES_C;
          end
        end else begin
          state_d     = ST_PLAY;
          hit_timer_d = hit_timer_q;
        end
      end
      ST_HIT: begin
        if (tick_go_s) begin
          // A timer already at 0 is treated as expired rather than wrapping.
          if (hit_timer_q <= 8'd1) begin
            state_d     = ST_PLAY;
            hit_timer_d = 8'd0;
          end else begin
            state_d     = ST_HIT;
            hit_timer_d = hit_timer_q - 8'd1;
          end
        end else begin
          state_d     = ST_HIT;
          hit_timer_d = hit_timer_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        hit_timer_d = 8'd0;
      end
    endcase
  end

  // Output/datapath logic: pending latches, score, lives, fruit position, pulses.
  always_comb begin
    lives_d     = lives_q;
    score_d     = score_q;
    speed_cnt_d = speed_cnt_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    move_d      = 1'b0;
    set_speed_d = 1'b0;

    if (start_go_s || tick_go_s) begin
      fruit_pend_d   = 1'b0;
      barrier_pend_d = 1'b0;
    end else begin
      fruit_pend_d   = fruit_now_s;
      barrier_pend_d = barrier_now_s;
    end

    if (start_go_s) begin
      lives_d     = LIVES_INIT_C;
      score_d     = '0;
      speed_cnt_d = 8'd0;
      pos_x_d     = FRUIT_X0_C;
      pos_y_d     = FRUIT_Y0_C;
      move_d      = 1'b1;
    end else begin
      if (fruit_apply_s) begin
        if (score_q == SCORE_MAX) begin
          score_d = score_q;
        end else begin
          score_d = score_q + SCORE_ONE;
        end
        pos_x_d = X_MIN_C + {2'b00, lfsr_q[8:0]};
        pos_y_d = Y_MIN_C + {2'b00, lfsr_q[15:8]};
        move_d  = 1'b1;
        if (speed_inc_s == SPEED_STEP_C) begin
          speed_cnt_d = 8'd0;
          set_speed_d = 1'b1;
        end else begin
          speed_cnt_d = speed_inc_s;
          set_speed_d = 1'b0;
        end
      end else begin
        score_d = score_q;
      end
      if (barrier_apply_s) begin
        lives_d = lives_dec_s;
      end else begin
        lives_d = lives_q;
      end
    end

    // HIT blinks by alternating 001/010 on the parity of the hit timer.
    case (state_d)
      ST_IDLE: state_game_d = 3'b000;
      ST_PLAY: state_game_d = 3'b001;
      ST_HIT: begin
        if (hit_timer_d[0]) begin
          state_game_d = 3'b010;
        end else begin
          state_game_d = 3'b001;
        end
      end
      ST_OVER: state_game_d = 3'b100;
      default: state_game_d = 3'b000;
    endcase

    heart_d = hearts(lives_d);
  end

  assign state_game_o     = state_game_q;
  assign lives_o          = lives_q;
  assign heart_en_o       = heart_q;
  assign score_o          = score_q;
  assign set_speed_o      = set_speed_q;
  assign new_position_x_o = pos_x_q;
  assign new_position_y_o = pos_y_q;
  assign move_sprite_o    = move_q;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Frame-synchronous game controller that sequences the sprite compositor: it owns the `stateGame` code, lives/heart visibility, score, speed-up requests and fruit respawn position. Collision flags from the pixel pipeline are latched during a frame and applied only on the end-of-frame tick, so no sprite moves or changes mid-frame. Its outputs drive `stateGame`, `setSpeed`, the heart sprite enables and the fruit `new_position_x/y`/`moveSprite` inputs of the compositor.

## Interface

**Parameters**

- `LIVES_INIT`, 3 — lives on game start, 1..3.
- `HIT_FRAMES`, 60 — invulnerability duration in frames after a barrier hit, 1..255.
- `SPEED_STEP`, 5 — fruits eaten per `set_speed` pulse, 1..255.
- `FRUIT_X0`, 400 — fruit x position on start.
- `FRUIT_Y0`, 400 — fruit y position on start.
- `X_MIN`, 50 — base of the random x range.
- `Y_MIN`, 50 — base of the random y range.
- `SCORE_W`, 8 — score width.

**Ports** (clock and reset first)

- `clk`, input, 1 — system/pixel clock.
- `reset`, input, 1 — synchronous, active-high.
- `start`, input, 1 — one-cycle start/restart pulse.
- `frame_tick`, input, 1 — one-cycle pulse at end of the visible frame.
- `hit_fruit`, input, 1 — snake head overlaps fruit this cycle.
- `hit_barrier`, input, 1 — snake head overlaps barrier this cycle.
- `state_game`, output, 3 — compositor state code.
- `lives`, output, 2 — remaining lives.
- `heart_en`, output, 3 — heart visibility, thermometer-coded from `lives`.
- `score`, output, SCORE_W — fruits eaten, saturating.
- `set_speed`, output, 1 — one-cycle speed-up pulse.
- `new_position_x`, output, 11 — fruit x position.
- `new_position_y`, output, 10 — fruit y position.
- `move_sprite`, output, 1 — one-cycle pulse; the fruit adopts the new position.

## Operation

**FSM states:** IDLE, PLAY, HIT, OVER. `state_game` encoding: IDLE=000, PLAY=001, OVER=100. In HIT, `state_game` is 001 on even hit-timer values and 010 on odd ones, so gameplay sprites blink.

**LFSR:** 16-bit Galois, mask 16'hB400, seed 16'hACE1 on reset. Advances every clock in all states.

**Start** (in IDLE or OVER):
- `lives`=LIVES_INIT, `score`=0, speed counter=0, pending flags cleared.
- `new_position`=(FRUIT_X0, FRUIT_Y0), pulse `move_sprite`, go to PLAY.
- `start` is ignored in PLAY and HIT.

**Pending latches:**
- `fruit_pend` is set by `hit_fruit` in PLAY or HIT.
- `barrier_pend` is set by `hit_barrier` in PLAY only.
- Both clear on the `frame_tick` that processes them. A hit in the same cycle as `frame_tick` counts for that tick.

**On `frame_tick` in PLAY or HIT:**
- **Fruit** (if `fruit_pend`):
  - `score`+1, saturating at all-ones.
  - `new_position_x` = X_MIN + lfsr[8:0]; `new_position_y` = Y_MIN + lfsr[15:8].
  - Pulse `move_sprite`.
  - Speed counter +1; when it reaches SPEED_STEP it clears to 0 and pulses `set_speed`.
- **Barrier** (PLAY only, if `barrier_pend`):
  - `lives`−1.
  - If the result is 0, go to OVER; otherwise go to HIT with hit timer = HIT_FRAMES.
- **Both pending:** both actions apply on the same tick.
- **HIT:** the hit timer decrements per tick. The tick that reaches 0 returns to PLAY.

**Other rules:**
- `heart_en` = {lives≥3, lives≥2, lives≥1}.
- OVER holds `score` and `lives`=0 until `start`.
- `reset` mid-game returns every register to its reset value on the next edge, regardless of state.

## Timing

- All outputs are registered; they update on the `clk` edge where `frame_tick` or `start` is sampled high (visible the cycle after).
- `move_sprite` and `set_speed` are high for exactly one cycle.
- Collision-to-effect latency: up to one frame plus one cycle.
- Reset values:
  - `state_game`=000, `lives`=0, `heart_en`=000, `score`=0.
  - `set_speed`=0, `move_sprite`=0.
  - `new_position_x`=FRUIT_X0, `new_position_y`=FRUIT_Y0.
  - Internal: hit timer 0, speed counter 0, pending flags 0, LFSR=16'hACE1.
- `start` and `frame_tick` in the same cycle in IDLE/OVER: start wins, the tick is ignored.
- `frame_tick` in IDLE/OVER: no effect.
- Width rules:
  - x = 11-bit sum, range 50..561.
  - y = 10-bit sum, range 50..305.
  - No clamping needed with the default X_MIN/Y_MIN.

## Test plan

- **Reset, then start:** reset, then `start` → next cycle `state_game`=001, `lives`=3, `heart_en`=111, `move_sprite`=1 with (400,400), `score`=0.
- **Fruit scoring and speed-up:** five fruit hits on five separate frames → `score`=5, `set_speed` pulses once, on the 5th tick. Each tick pulses `move_sprite` with x∈[50,561], y∈[50,305], matching a reference LFSR model.
- **Barrier hit and invulnerability:** barrier hit in PLAY →
  - After the tick: `lives`=2, `heart_en`=011, HIT.
  - Further barrier hits for 60 ticks are ignored, and `state_game` alternates 001/010.
  - After tick 60: PLAY.
- **Game over:** three barrier hits separated by HIT recovery → OVER, `state_game`=100, `lives`=0, `heart_en`=000. `frame_tick` is ignored; `start` restarts with `lives`=3 and `score`=0.
- **Simultaneous events:**
  - Fruit and barrier hits in the same frame → one tick applies `score`+1, `move_sprite`, and `lives`−1.
  - Hit asserted in the tick cycle itself counts.
  - `start`+`frame_tick` together in OVER → PLAY.
- **Reset mid-game:** `reset` asserted during HIT with score 7 → next cycle all outputs at their reset values. Pending hits from before reset have no effect after it.
